temp_sensor_reader: RTL and testbench
=====================================

Name: temp_sensor_reader

Overview:
SPI master for a MAX6675-style thermocouple converter. It periodically reads one 16-bit frame and decodes the temperature to an 8-bit integer °C value. This block is the producer of the 8-bit temperature bus consumed by the heater on/off/PWM controller, so it sits between the sensor pins and that controller. Sensor faults force a fail-safe reading of 8'hFF, which makes the controller switch the heater off.

Parameters:
CLK_DIV, 50, clk_i cycles per SCK half-period (50 gives 1 MHz at 100 MHz); legal range ≥ 4.
CONV_WAIT, 25_000_000, idle cycles between frames (sensor conversion time, 250 ms at 100 MHz); legal range ≥ 1.

Ports:
clk_i  in  1  system clock, 100 MHz
rst_i  in  1  synchronous reset, active-high
miso_i  in  1  sensor SO, asynchronous to clk_i
sck_o  out  1  SPI clock, idles low
cs_n_o  out  1  sensor chip select, active-low
temp_o  out  8  last decoded temperature, integer °C
valid_o  out  1  one-cycle pulse when temp_o/fault_o update
fault_o  out  1  sticky until next good frame: open thermocouple or framing error
busy_o  out  1  high while cs_n_o is low

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: cs_n_o=1, sck_o=0, temp_o=0, valid_o=0, fault_o=0, busy_o=0. State = WAIT with the wait counter cleared.
- Input sync: miso_i passes through a 2-flop synchronizer before use. CLK_DIV ≥ 4 guarantees the synchronized data is settled at sample time.
- WAIT: counts CONV_WAIT cycles, then goes to SETUP. The first frame after reset is also preceded by a full CONV_WAIT.
- SETUP:
  - cs_n_o=0, sck_o=0 for CLK_DIV cycles, then goes to SHIFT with bit counter = 15.
- SHIFT, per bit:
  - sck_o high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - On the clk_i edge where sck_o goes 0→1, shift the synchronized miso into the frame register, MSB first.
  - After the low phase of bit 0, go to UPDATE.
  - cs_n_o low time is exactly 33*CLK_DIV cycles, with exactly 16 sck_o rising edges.
- UPDATE (1 cycle): cs_n_o=1, frame decoded, valid_o=1 in this cycle only, then back to WAIT with the counter restarted.
- Decode (frame[15:0]):
  - Framing error: frame[15]=1 or frame[1]=1 → fault_o=1, temp_o=8'hFF.
  - Open thermocouple: else if frame[2]=1 → fault_o=1, temp_o=8'hFF.
  - Normal: else raw = frame[14:5] (10-bit integer °C; quarter-degree bits [4:3] are truncated, not rounded).
    - temp_o = raw if raw ≤ 255, else 8'hFF (saturate).
    - fault_o = 0.
- Holding: temp_o and fault_o hold between UPDATE cycles. Consumers may sample temp_o at any time.
- busy_o = ~cs_n_o.
- Reset mid-frame: the next clock drives cs_n_o=1 and sck_o=0. The partial frame is discarded, outputs return to reset values, and no valid_o pulse is produced.
- No external start input. Operation is free-running.

Decomposition:
- Package temp_sensor_pkg holds:
  - FRAME_W = 16;
  - bit positions TEMP_MSB = 14, TEMP_LSB = 5, OPEN_BIT = 2, ID_BIT = 1, DUMMY_BIT = 15;
  - FAIL_TEMP = 8'hFF;
  - the state encoding WAIT/SETUP/SHIFT/UPDATE.
- One sub-module: sck_tick_gen. It is a CLK_DIV counter producing a half-period tick, enabled only in SETUP/SHIFT and cleared otherwise.
- Frame shift register, decode and FSM stay in temp_sensor_reader.

Test Plan:
All scenarios use CLK_DIV=4 and CONV_WAIT=100, with a sensor model driving each bit on the sck_o falling edge (first bit driven on the cs_n_o fall).
- Normal read, frame 16'h0C80 → temp_o=8'h64 (100 °C), fault_o=0, exactly one valid_o pulse.
- Normal read, frame 16'h0500 → temp_o=8'h28 (40 °C). Frame 16'h0506 with bits [2:1]=11 → fault_o=1, temp_o=8'hFF.
- Open thermocouple, frame 16'h0004 → fault_o=1, temp_o=8'hFF. Following frame 16'h03F8 (raw 31) → temp_o=8'h1F, fault_o=0.
- Over-range, frame 16'h3E80 (500 °C) → temp_o=8'hFF, fault_o=0.
- Timing check:
  - first cs_n_o fall at cycle 100 after reset release;
  - cs_n_o low for 132 cycles with 16 sck_o rises at an 8-cycle period;
  - valid_o one cycle after cs_n_o rise;
  - next cs_n_o fall 100 cycles after UPDATE.
- Reset asserted during bit 7 → next cycle cs_n_o=1, sck_o=0, temp_o=0, no valid_o. After release, the first frame starts after a full 100-cycle wait.

Source files
------------

// File: rtl/temp_sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : temp_sensor_pkg
// Brief    : Frame layout, FSM encoding and decode helper for the
//            MAX6675-style thermocouple reader.
// Revision : 1.0 - initial release
// ============================================================================
package temp_sensor_pkg;

    localparam int FRAME_W   = 16;
    localparam int TEMP_MSB  = 14;
    localparam int TEMP_LSB  = 5;
    localparam int OPEN_BIT  = 2;
    localparam int ID_BIT    = 1;
    localparam int DUMMY_BIT = 15;
    localparam int RAW_W     = TEMP_MSB - TEMP_LSB + 1;

    localparam logic [7:0] FAIL_TEMP = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] temp;
        logic       fault;
    } reading_t;

    // Framing errors and open thermocouple both collapse to the fail-safe value.
    function automatic reading_t decode_frame(input logic [FRAME_W-1:0] frame);
        reading_t         r;
        logic [RAW_W-1:0] raw;
        raw = frame[TEMP_MSB:TEMP_LSB];
        if (frame[DUMMY_BIT] || frame[ID_BIT] || frame[OPEN_BIT]) begin
            r.temp  = FAIL_TEMP;
            r.fault = 1'b1;
        end else begin
            r.fault = 1'b0;
            r.temp  = (|raw[RAW_W-1:8]) ? FAIL_TEMP : raw[7:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/temp_sensor_reader_sck_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : sck_tick_gen
// Brief    : Half-period tick for SCK; counts CLK_DIV cycles while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module sck_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_en,
    output logic o_tick
);

    localparam int                  c_cnt_w = $clog2(CLK_DIV);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == c_last);

    // Cleared whenever disabled so every frame starts on a full half-period.
    always_ff @(posedge clk_i) begin
        if (rst_i || !i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/temp_sensor_reader.sv
`default_nettype none
// ============================================================================
// Module   : temp_sensor_reader
// Brief    : Free-running SPI master reading a MAX6675-style thermocouple
//            converter and publishing an 8-bit integer temperature.
// Revision : 1.0 - initial release
// ============================================================================
module temp_sensor_reader
    import temp_sensor_pkg::*;
#(
    parameter int CLK_DIV   = 50,
    parameter int CONV_WAIT = 25_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       cs_n_o,
    output logic [7:0] temp_o,
    output logic       valid_o,
    output logic       fault_o,
    output logic       busy_o
);

    localparam int                 c_wait_w    = $clog2(CONV_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(CONV_WAIT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_sync;
    logic                 w_miso_s;
    logic [c_wait_w-1:0]  r_wait_cnt;
    logic [c_wait_w-1:0]  w_wait_nxt;
    logic [3:0]           r_bit_cnt;
    logic [3:0]           w_bit_nxt;
    logic                 r_sck;
    logic                 w_sck_nxt;
    logic                 w_shift;
    logic                 w_update;
    logic                 w_tick;
    logic                 w_active;
    logic [FRAME_W-1:0]   r_frame;
    logic [7:0]           r_temp;
    logic                 r_fault;
    logic                 r_valid;
    reading_t             w_reading;

    assign w_miso_s  = r_sync[1];
    assign w_active  = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
    assign w_reading = decode_frame(r_frame);

    assign cs_n_o  = ~w_active;
    assign busy_o  = w_active;
    assign sck_o   = r_sck;
    assign temp_o  = r_temp;
    assign fault_o = r_fault;
    assign valid_o = r_valid;

    sck_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_en   (w_active),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        w_bit_nxt   = r_bit_cnt;
        w_sck_nxt   = r_sck;
        w_shift     = 1'b0;
        w_update    = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT;
                    w_sck_nxt   = 1'b1;
                    w_bit_nxt   = 4'd15;
                    w_shift     = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Data is captured on the same edge that raises SCK.
                if (w_tick) begin
                    if (r_sck) begin
                        w_sck_nxt = 1'b0;
                    end else if (r_bit_cnt == 4'd0) begin
                        w_state_nxt = ST_UPDATE;
                    end else begin
                        w_sck_nxt = 1'b1;
                        w_bit_nxt = r_bit_cnt - 1'b1;
                        w_shift   = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                w_state_nxt = ST_WAIT;
                w_update    = 1'b1;
            end
            default: begin
                w_state_nxt = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync     <= '0;
            r_wait_cnt <= '0;
            r_bit_cnt  <= '0;
            r_sck      <= 1'b0;
            r_frame    <= '0;
            r_temp     <= '0;
            r_fault    <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], miso_i};
            r_wait_cnt <= w_wait_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_sck      <= w_sck_nxt;
            r_valid    <= w_update;
            if (w_shift) begin
                r_frame <= {r_frame[FRAME_W-2:0], w_miso_s};
            end
            if (w_update) begin
                r_temp  <= w_reading.temp;
                r_fault <= w_reading.fault;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_temp_sensor_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_sensor_reader
// Brief    : Self-checking bench with a bit-level sensor model and an
//            arithmetic reference decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_sensor_reader;

    localparam int CLK_DIV   = 4;
    localparam int CONV_WAIT = 100;
    localparam int LIMIT     = 2000;

    logic       clk_i  = 1'b0;
    logic       rst_i  = 1'b1;
    logic       miso_i = 1'b0;
    logic       sck_o;
    logic       cs_n_o;
    logic [7:0] temp_o;
    logic       valid_o;
    logic       fault_o;
    logic       busy_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t_valid     = 0;

    logic [15:0] tx_frame = 16'h0000;
    logic [15:0] sh       = 16'h0000;
    int          bidx     = 0;
    bit          in_frame = 1'b0;

    temp_sensor_reader #(
        .CLK_DIV   (CLK_DIV),
        .CONV_WAIT (CONV_WAIT)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .miso_i  (miso_i),
        .sck_o   (sck_o),
        .cs_n_o  (cs_n_o),
        .temp_o  (temp_o),
        .valid_o (valid_o),
        .fault_o (fault_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rst_i) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Sensor: first bit on CS fall, each later bit on an SCK fall.
    always @(cs_n_o or negedge sck_o) begin
        if (cs_n_o) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            sh       = tx_frame;
            bidx     = 15;
            miso_i   = sh[15];
        end else if (!sck_o && bidx > 0) begin
            bidx   = bidx - 1;
            miso_i = sh[bidx];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] f, output logic [7:0] t, output logic flt);
        int v;
        int raw;
        v   = int'(f);
        raw = (v / 32) % 1024;
        if (v >= 32768 || ((v / 2) % 2) == 1 || ((v / 4) % 2) == 1) begin
            t   = 8'd255;
            flt = 1'b1;
        end else begin
            t   = (raw > 255) ? 8'd255 : raw[7:0];
            flt = 1'b0;
        end
    endfunction

    task automatic run_frame(input logic [15:0] f, input bit first);
        int         t_fall;
        int         t_rise;
        int         rises;
        int         n;
        bit         spacing_ok;
        bit         valid_early;
        logic       sck_prev;
        logic [7:0] et;
        logic       ef;
        model(f, et, ef);
        tx_frame    = f;
        n           = 0;
        valid_early = 1'b0;
        while (cs_n_o && n < LIMIT) begin
            @(negedge clk_i);
            n++;
            if (valid_o) valid_early = 1'b1;
        end
        chk("cs_fall_timeout", 32'(n < LIMIT), 32'd1);
        t_fall = cyc;
        if (first) chk("first_fall_cycle", 32'(t_fall), 32'(CONV_WAIT));
        else       chk("fall_after_valid", 32'(t_fall - t_valid), 32'(CONV_WAIT));
        sck_prev   = 1'b0;
        rises      = 0;
        spacing_ok = 1'b1;
        n          = 0;
        while (!cs_n_o && n < LIMIT) begin
            if (sck_o && !sck_prev) begin
                rises++;
                if (((cyc - t_fall - CLK_DIV) % (2 * CLK_DIV)) != 0) spacing_ok = 1'b0;
            end
            if (valid_o) valid_early = 1'b1;
            sck_prev = sck_o;
            @(negedge clk_i);
            n++;
        end
        t_rise = cyc;
        chk("cs_low_cycles", 32'(t_rise - t_fall), 32'(33 * CLK_DIV));
        chk("sck_rises", 32'(rises), 32'd16);
        chk("sck_spacing", 32'(spacing_ok), 32'd1);
        chk("no_early_valid", 32'(valid_early), 32'd0);
        chk("valid_at_update", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        t_valid = cyc;
        chk("valid_pulse", 32'(valid_o), 32'd1);
        chk("temp", 32'(temp_o), 32'(et));
        chk("fault", 32'(fault_o), 32'(ef));
        @(negedge clk_i);
        chk("valid_one_cycle", 32'(valid_o), 32'd0);
        chk("temp_hold", 32'(temp_o), 32'(et));
    endtask

    initial begin
        logic [15:0] f;
        int          n;
        int          rises;
        logic        sck_prev;

        repeat (3) @(negedge clk_i);
        chk("rst_cs_n", 32'(cs_n_o), 32'd1);
        chk("rst_sck", 32'(sck_o), 32'd0);
        chk("rst_temp", 32'(temp_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;

        run_frame(16'h0C80, 1'b1);
        run_frame(16'h0500, 1'b0);
        run_frame(16'h0506, 1'b0);
        run_frame(16'h0004, 1'b0);
        run_frame(16'h03F8, 1'b0);
        run_frame(16'h3E80, 1'b0);
        for (int i = 0; i < 6; i++) begin
            f = 16'($urandom_range(0, 65535));
            if (i % 2 == 0) f = f & 16'h7FF9;
            run_frame(f, 1'b0);
        end
        run_frame(16'h0C80, 1'b0);

        // Reset while bit 7 is being clocked.
        tx_frame = 16'h0A40;
        n        = 0;
        while (cs_n_o && n < LIMIT) begin
            @(negedge clk_i);
            n++;
        end
        rises    = 0;
        sck_prev = 1'b0;
        while (rises < 9 && n < LIMIT) begin
            @(negedge clk_i);
            n++;
            if (sck_o && !sck_prev) rises++;
            sck_prev = sck_o;
        end
        chk("mid_reset_reach_bit7", 32'(rises), 32'd9);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_cs_n", 32'(cs_n_o), 32'd1);
        chk("mid_rst_sck", 32'(sck_o), 32'd0);
        chk("mid_rst_temp", 32'(temp_o), 32'd0);
        chk("mid_rst_fault", 32'(fault_o), 32'd0);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        run_frame(16'h0500, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
